// File: rtl/aes128_enc_iter_pkg.sv
// Shared AES-128 constants, FSM encoding and GF(2^8) helpers for the iterative encryption engine.
package aes128_enc_iter_pkg;

    localparam int unsigned NR   = 10;
    localparam int unsigned KS_W = 128 * (NR + 1);

    typedef enum logic [1:0] {StIdle, StRound, StHold} fsm_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (b^254 by square-and-multiply) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = b;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] rk(input logic [KS_W-1:0] sched, input int unsigned r);
        return sched[KS_W-1-128*r -: 128];
    endfunction

endpackage

// File: rtl/aes128_enc_iter_if.sv
// Plaintext-in / ciphertext-out handshake bundle, with the key schedule carried alongside.
interface aes128_enc_iter_if;
    import aes128_enc_iter_pkg::*;

    logic [KS_W-1:0] key_sched;
    logic            in_valid;
    logic            in_ready;
    logic [127:0]    datain;
    logic            out_valid;
    logic            out_ready;
    logic [127:0]    dataout;
    logic            busy;

    modport master (
        output key_sched, in_valid, datain, out_ready,
        input  in_ready, out_valid, dataout, busy
    );

    modport slave (
        input  key_sched, in_valid, datain, out_ready,
        output in_ready, out_valid, dataout, busy
    );

endinterface

// File: rtl/aes128_enc_iter_round.sv
// One combinational AES cipher round: SubBytes, ShiftRows, MixColumns (skipped on the final
// round) and AddRoundKey. Byte i of the state sits at bits [127-8i -: 8], column-major.
module aes128_enc_iter_round
    import aes128_enc_iter_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] rkey_i,
    input  logic         final_i,
    output logic [127:0] state_o
);

    logic [127:0] sub;
    logic [127:0] shf;
    logic [127:0] mix;

    always_comb begin
        sub = '0;
        shf = '0;
        mix = '0;
        for (int i = 0; i < 16; i++) begin
            sub[127-8*i -: 8] = sbox(state_i[127-8*i -: 8]);
        end
        // Row r of column c takes the byte from column (c + r) mod 4.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shf[127-8*(r+4*c) -: 8] = sub[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mix[127-32*c -: 32] = mix_column(shf[127-32*c -: 32]);
        end
        state_o = (final_i ? shf : mix) ^ rkey_i;
    end

endmodule

// File: rtl/aes128_enc_iter.sv
// Iterative AES-128 encryption engine: one reused round datapath, one round per clock, with
// ciphertext held under a valid/ready handshake.
module aes128_enc_iter
    import aes128_enc_iter_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    aes128_enc_iter_if.slave    bus
);

    fsm_e         st_q, st_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] state_q, state_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic         busy_q, busy_d;

    logic [3:0]   rk_sel;
    logic [127:0] rkey;
    logic [127:0] round_out;
    logic         last_round;

    // Out-of-range counts select key 0 so the slice never leaves the schedule.
    always_comb begin
        rk_sel     = (st_q == StRound && round_q <= 4'(NR)) ? round_q : 4'd0;
        last_round = (round_q == 4'(NR));
        rkey       = rk(bus.key_sched, 32'(rk_sel));
    end

    aes128_enc_iter_round u_round (
        .state_i (state_q),
        .rkey_i  (rkey),
        .final_i (last_round),
        .state_o (round_out)
    );

    always_comb begin
        st_d    = st_q;
        round_d = round_q;
        state_d = state_q;
        if (round_q > 4'(NR)) begin
            st_d    = StIdle;
            round_d = 4'd0;
        end else begin
            case (st_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        state_d = bus.datain ^ rkey;
                        round_d = 4'd1;
                        st_d    = StRound;
                    end
                end
                StRound: begin
                    if (round_q == 4'd0) begin
                        st_d = StIdle;
                    end else begin
                        state_d = round_out;
                        if (last_round) begin
                            st_d    = StHold;
                            round_d = 4'd0;
                        end else begin
                            round_d = round_q + 4'd1;
                        end
                    end
                end
                StHold: begin
                    if (bus.out_ready) st_d = StIdle;
                end
                default: begin
                    st_d    = StIdle;
                    round_d = 4'd0;
                end
            endcase
        end
        in_ready_d  = (st_d == StIdle);
        out_valid_d = (st_d == StHold);
        busy_d      = (st_d == StRound);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= StIdle;
            round_q     <= 4'd0;
            state_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            st_q        <= st_d;
            round_q     <= round_d;
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.dataout   = state_q;

endmodule
